// File: rtl/uart_pkg.sv
// UART shared package.
// Holds the receiver FSM state encoding, the data-bits field encoding, the
// parity-type constant and the parity helper function. The RX core imports it,
// and any TX or loopback logic can import it too.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        COMMIT = 3'd5,
        BREAK  = 3'd6
    } uart_rx_state_e;

    // data_bits field encoding: character length is the field value plus 5.
    localparam logic [1:0] DATA_BITS_5 = 2'd0;
    localparam logic [1:0] DATA_BITS_6 = 2'd1;
    localparam logic [1:0] DATA_BITS_7 = 2'd2;
    localparam logic [1:0] DATA_BITS_8 = 2'd3;

    // parity_type value that selects odd parity.
    localparam logic PARITY_ODD = 1'b1;

    // Expected parity bit. Callers must zero the unused upper data bits.
    function automatic logic parity_expected(input logic [7:0] data, input logic parity_type);
        return (^data) ^ (parity_type == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchronizer for one asynchronous serial line.
// Both flops reset to 1, which is the idle level of a UART line.
// Ports:
//   clk_i   - destination clock
//   arst_ni - asynchronous active-low reset
//   d_i     - asynchronous input
//   q_o     - synchronized output
module uart_bit_sync (
    input  logic clk_i,
    input  logic arst_ni,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    // Two-stage synchronizer chain, preset to the idle-high level.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver core.
// It samples each bit of rx_i at mid-bit, using a down-counter loaded from the
// programmable divider. It checks optional parity and the stop bit. Each
// finished character goes into a single-entry valid/ready output register.
// Ports:
//   clk_i, arst_ni            - clock, asynchronous active-low reset
//   rx_i                      - asynchronous serial input (idles high)
//   clk_div_i                 - clock cycles per bit; values below MIN_CLK_DIV are clamped up
//   parity_en_i/parity_type_i - parity enable, 1 = odd
//   data_bits_i               - character length, 0..3 -> 5..8 bits
//   data_o/parity_err_o/frame_err_o/valid_o, ready_i - output register and handshake
//   overrun_o                 - one-cycle pulse when a finished character is dropped
//   busy_o                    - FSM is not in IDLE
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int MIN_CLK_DIV = 4,
    parameter int DIV_W       = 16
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             rx_i,
    input  logic [DIV_W-1:0] clk_div_i,
    input  logic             parity_en_i,
    input  logic             parity_type_i,
    input  logic [1:0]       data_bits_i,
    output logic [7:0]       data_o,
    output logic             parity_err_o,
    output logic             frame_err_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             overrun_o,
    output logic             busy_o
);

    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(MIN_CLK_DIV);
    localparam logic [DIV_W-1:0] ONE     = DIV_W'(1);

    uart_rx_state_e   r_state;
    uart_rx_state_e   w_next_state;

    logic             w_rx_s;
    logic             r_rx_prev;
    logic [1:0]       r_warm;
    logic             w_fall;

    logic [DIV_W-1:0] w_div_clamped;
    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic             r_par_en;
    logic             r_par_odd;
    logic [1:0]       r_data_bits;
    logic [7:0]       r_shift;
    logic [2:0]       r_idx;
    logic             r_rx_par;
    logic             r_stop_bit;

    logic             w_tc;
    logic             w_last_bit;
    logic             w_par_err;

    logic             w_cap_cfg;
    logic             w_start_ok;
    logic             w_cnt_reload;
    logic             w_cnt_dec;
    logic             w_data_smp;
    logic             w_par_smp;
    logic             w_stop_smp;
    logic             w_commit;

    uart_bit_sync u_rx_sync (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .d_i     (rx_i),
        .q_o     (w_rx_s)
    );

    assign w_div_clamped = (clk_div_i < MIN_DIV) ? MIN_DIV : clk_div_i;
    assign w_tc          = (r_cnt == {DIV_W{1'b0}});
    assign w_last_bit    = (r_idx == ({1'b0, r_data_bits} + 3'd4));
    assign w_par_err     = r_par_en & (r_rx_par != parity_expected(r_shift, r_par_odd));

    // Edge detection stays gated until the preset synchronizer holds a real
    // sample. Without the gate, a line held low at reset release would show
    // up as a start edge.
    assign w_fall = (r_warm == 2'd3) && r_rx_prev && !w_rx_s;

    // Previous synchronized line level and the post-reset warm-up count.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_rx_prev <= 1'b1;
            r_warm    <= 2'd0;
        end else begin
            r_rx_prev <= w_rx_s;
            if (r_warm != 2'd3) begin
                r_warm <= r_warm + 2'd1;
            end else begin
                r_warm <= r_warm;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_fall) begin
                    w_next_state = START;
                end else begin
                    w_next_state = IDLE;
                end
            end
            START: begin
                if (w_tc) begin
                    w_next_state = w_rx_s ? IDLE : DATA;
                end else begin
                    w_next_state = START;
                end
            end
            DATA: begin
                if (w_tc && w_last_bit) begin
                    w_next_state = r_par_en ? PARITY : STOP;
                end else begin
                    w_next_state = DATA;
                end
            end
            PARITY: begin
                if (w_tc) begin
                    w_next_state = STOP;
                end else begin
                    w_next_state = PARITY;
                end
            end
            STOP: begin
                if (w_tc) begin
                    w_next_state = COMMIT;
                end else begin
                    w_next_state = STOP;
                end
            end
            // A low stop bit means a break or a stuck-low line. BREAK waits
            // for the line to go high, so the frame cannot retrigger.
            COMMIT: begin
                w_next_state = r_stop_bit ? IDLE : BREAK;
            end
            BREAK: begin
                if (w_rx_s) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = BREAK;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // FSM output decode: datapath strobes for the counter, samplers and commit.
    always_comb begin
        w_cap_cfg    = 1'b0;
        w_start_ok   = 1'b0;
        w_cnt_reload = 1'b0;
        w_cnt_dec    = 1'b0;
        w_data_smp   = 1'b0;
        w_par_smp    = 1'b0;
        w_stop_smp   = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE: begin
                w_cap_cfg = w_fall;
            end
            START: begin
                if (w_tc) begin
                    w_start_ok   = !w_rx_s;
                    w_cnt_reload = !w_rx_s;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            DATA: begin
                if (w_tc) begin
                    w_data_smp   = 1'b1;
                    w_cnt_reload = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            PARITY: begin
                if (w_tc) begin
                    w_par_smp    = 1'b1;
                    w_cnt_reload = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            STOP: begin
                if (w_tc) begin
                    w_stop_smp = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            COMMIT: begin
                w_commit = 1'b1;
            end
            BREAK: begin
                w_commit = 1'b0;
            end
            default: begin
                w_commit = 1'b0;
            end
        endcase
    end

    // Datapath: configuration capture, bit counter, shift register and samplers.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_div       <= MIN_DIV;
            r_cnt       <= {DIV_W{1'b0}};
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_data_bits <= DATA_BITS_8;
            r_shift     <= 8'h00;
            r_idx       <= 3'd0;
            r_rx_par    <= 1'b0;
            r_stop_bit  <= 1'b1;
        end else begin
            // The first sample point is half a bit after the start edge.
            // Later sample points are one full bit apart.
            if (w_cap_cfg) begin
                r_div       <= w_div_clamped;
                r_par_en    <= parity_en_i;
                r_par_odd   <= parity_type_i;
                r_data_bits <= data_bits_i;
                r_cnt       <= (w_div_clamped >> 1) - ONE;
            end else if (w_cnt_reload) begin
                r_cnt <= r_div - ONE;
            end else if (w_cnt_dec) begin
                r_cnt <= r_cnt - ONE;
            end
            // Clear the shift register at frame start, so unused upper bits
            // read as 0 and drop out of the parity XOR.
            if (w_start_ok) begin
                r_shift <= 8'h00;
                r_idx   <= 3'd0;
            end else if (w_data_smp) begin
                r_shift[r_idx] <= w_rx_s;
                r_idx          <= r_idx + 3'd1;
            end
            if (w_par_smp) begin
                r_rx_par <= w_rx_s;
            end
            if (w_stop_smp) begin
                r_stop_bit <= w_rx_s;
            end
        end
    end

    // Output register: commit or overrun, handshake release, busy flag.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_o       <= 8'h00;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            valid_o      <= 1'b0;
            overrun_o    <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            busy_o    <= (w_next_state != IDLE);
            if (w_commit) begin
                if (!valid_o || ready_i) begin
                    data_o       <= r_shift;
                    parity_err_o <= w_par_err;
                    frame_err_o  <= !r_stop_bit;
                    valid_o      <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core. The stimulus pushes the expected
// characters into a queue. The monitor pops and compares one entry on each
// valid_o && ready_i handshake.
module tb_uart_rx_core;

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic        clk;
    logic        arst_ni;
    logic        rx;
    logic [15:0] clk_div;
    logic        parity_en;
    logic        parity_type;
    logic [1:0]  data_bits;
    logic        ready;
    logic [7:0]  data_o;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        valid_o;
    logic        overrun_o;
    logic        busy_o;

    int          total;
    int          bad;
    int          cyc;
    int          ovr_cnt;
    int          rise_cyc;
    int          start_cyc;
    logic        prev_valid;
    exp_t        sb[$];
    exp_t        e;

    localparam int B = 32;

    uart_rx_core #(.MIN_CLK_DIV(4), .DIV_W(16)) dut (
        .clk_i         (clk),
        .arst_ni       (arst_ni),
        .rx_i          (rx),
        .clk_div_i     (clk_div),
        .parity_en_i   (parity_en),
        .parity_type_i (parity_type),
        .data_bits_i   (data_bits),
        .data_o        (data_o),
        .parity_err_o  (parity_err_o),
        .frame_err_o   (frame_err_o),
        .valid_o       (valid_o),
        .ready_i       (ready),
        .overrun_o     (overrun_o),
        .busy_o        (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe);
        exp_t x;
        x.d  = d;
        x.pe = pe;
        x.fe = fe;
        sb.push_back(x);
    endtask

    // Serial driver. bitc is the number of clocks per bit. The parity bit is
    // computed from the transmitted bits.
    task automatic send_rx(input logic [7:0] data, input int bitc, input bit pen,
                           input bit podd, input int nstop, input int nbits);
        logic [7:0] full;
        logic [7:0] d;
        full = 8'hFF;
        d = data & (full >> (8 - nbits));
        @(negedge clk);
        rx = 1'b0;
        start_cyc = cyc;
        repeat (bitc) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            rx = d[i];
            repeat (bitc) @(negedge clk);
        end
        if (pen) begin
            rx = (^d) ^ podd;
            repeat (bitc) @(negedge clk);
        end
        rx = 1'b1;
        repeat (bitc * nstop) @(negedge clk);
    endtask

    task automatic wait_drain(input int maxc, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        total = total + 1;
        if (sb.size() != 0) begin
            bad = bad + 1;
            $display("FAIL %s_drain: pending=%0d required=0", name, sb.size());
            sb.delete();
        end
    endtask

    // Monitor: counts overrun pulses, timestamps valid_o rising edges and
    // checks every accepted character against the scoreboard.
    always @(negedge clk) begin
        if (overrun_o) ovr_cnt = ovr_cnt + 1;
        if (valid_o && !prev_valid) rise_cyc = cyc;
        prev_valid = valid_o;
        if (valid_o && ready) begin
            if (sb.size() == 0) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL unexpected_char: got data=%02h pe=%0b fe=%0b required none",
                         data_o, parity_err_o, frame_err_o);
            end else begin
                e = sb.pop_front();
                check("rx_data", 32'(data_o), 32'(e.d));
                check("rx_parity_err", 32'(parity_err_o), 32'(e.pe));
                check("rx_frame_err", 32'(frame_err_o), 32'(e.fe));
            end
        end
    end

    initial begin
        total = 0; bad = 0; cyc = 0; ovr_cnt = 0; rise_cyc = 0; start_cyc = 0;
        prev_valid = 1'b0;
        rx = 1'b1; arst_ni = 1'b0; ready = 1'b1;
        clk_div = 16'd868; parity_en = 1'b0; parity_type = 1'b0; data_bits = 2'd3;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data", 32'(data_o), 32'h0);
        check("rst_valid", 32'(valid_o), 32'h0);
        check("rst_perr", 32'(parity_err_o), 32'h0);
        check("rst_ferr", 32'(frame_err_o), 32'h0);
        check("rst_overrun", 32'(overrun_o), 32'h0);
        check("rst_busy", 32'(busy_o), 32'h0);
        arst_ni = 1'b1;
        repeat (10) @(negedge clk);

        // 8N1 at div 868, plus a latency window
        push(8'hA5, 1'b0, 1'b0);
        send_rx(8'hA5, 868, 0, 0, 1, 8);
        wait_drain(200, "8n1");
        check("lat_8n1", 32'((rise_cyc - start_cyc >= 8240) && (rise_cyc - start_cyc <= 8260)), 32'h1);

        clk_div = 16'(B);

        // Odd parity: matching sender, then an even-parity sender
        parity_en = 1'b1; parity_type = 1'b1;
        push(8'h3C, 1'b0, 1'b0);
        send_rx(8'h3C, B, 1, 1, 1, 8);
        wait_drain(200, "odd_ok");
        push(8'h3C, 1'b1, 1'b0);
        send_rx(8'h3C, B, 1, 0, 1, 8);
        wait_drain(200, "odd_bad");
        parity_en = 1'b0; parity_type = 1'b0;

        // 5-bit and 7-bit characters
        data_bits = 2'd0;
        push(8'h1F, 1'b0, 1'b0);
        send_rx(8'hFF, B, 0, 0, 1, 5);
        wait_drain(200, "5bit");
        data_bits = 2'd2;
        push(8'h55, 1'b0, 1'b0);
        send_rx(8'h55, B, 0, 0, 1, 7);
        wait_drain(200, "7bit");
        data_bits = 2'd3;

        // A divider below the minimum is clamped to 4 clocks per bit
        clk_div = 16'd2;
        push(8'h96, 1'b0, 1'b0);
        send_rx(8'h96, 4, 0, 0, 1, 8);
        wait_drain(200, "clamp");
        clk_div = 16'(B);

        // Break: line low for 12 bit times
        push(8'h00, 1'b0, 1'b1);
        @(negedge clk);
        rx = 1'b0;
        repeat (12 * B) @(negedge clk);
        check("break_busy", 32'(busy_o), 32'h1);
        wait_drain(10, "break");
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("break_idle", 32'(busy_o), 32'h0);

        // Short glitch: no character
        rx = 1'b0;
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (100) @(negedge clk);
        check("glitch_idle", 32'(busy_o), 32'h0);

        // Overrun under back-pressure
        ready = 1'b0;
        ovr_cnt = 0;
        push(8'h11, 1'b0, 1'b0);
        send_rx(8'h11, B, 0, 0, 1, 8);
        send_rx(8'h22, B, 0, 0, 1, 8);
        repeat (20) @(negedge clk);
        check("ovr_count", 32'(ovr_cnt), 32'h1);
        check("ovr_valid", 32'(valid_o), 32'h1);
        check("ovr_hold", 32'(data_o), 32'h11);
        ready = 1'b1;
        wait_drain(10, "ovr_accept");
        push(8'h33, 1'b0, 1'b0);
        send_rx(8'h33, B, 0, 0, 1, 8);
        wait_drain(200, "after_ovr");
        check("ovr_count_final", 32'(ovr_cnt), 32'h1);

        // Reset during data bit 3 of 0xC3
        fork
            send_rx(8'hC3, B, 0, 0, 1, 8);
            begin
                repeat (4 * B + B / 2) @(negedge clk);
                check("mid_busy", 32'(busy_o), 32'h1);
                arst_ni = 1'b0;
                #1;
                check("mid_rst_valid", 32'(valid_o), 32'h0);
                check("mid_rst_data", 32'(data_o), 32'h0);
                check("mid_rst_busy", 32'(busy_o), 32'h0);
            end
        join
        // Release with the line held low: no frame may start
        rx = 1'b0;
        repeat (5) @(negedge clk);
        arst_ni = 1'b1;
        repeat (100) @(negedge clk);
        check("low_release_busy", 32'(busy_o), 32'h0);
        check("low_release_valid", 32'(valid_o), 32'h0);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        push(8'h7E, 1'b0, 1'b0);
        send_rx(8'h7E, B, 0, 0, 1, 8);
        wait_drain(200, "post_reset");
        repeat (50) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
